fetch_stage: RTL

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the PC, issues requests to instruction memory over a req/gnt/rvalid handshake, buffers returned words in a small FIFO, and drives the IF/ID pipeline register consumed by decode and by the hazard detector. It obeys `stall` (hold IF/ID) and `flush` (redirect to the EX branch/jump target and kill wrong-path fetches) from the hazard detector.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared RV32I pipeline types: NOP encoding, fetch FSM states and
//            the IF/ID register layout.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        valid;
   } if_id_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Instruction-memory req/gnt/rvalid bus between fetch and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;

   modport master (
      output o_imem_req, o_imem_addr,
      input  i_imem_gnt, i_imem_rvalid, i_imem_rdata
   );

   modport slave (
      input  o_imem_req, o_imem_addr,
      output i_imem_gnt, i_imem_rvalid, i_imem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO with push, pop, synchronous clear and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 32,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  wire logic             i_clk,
   input  wire logic             i_rst,
   input  wire logic             i_clr,
   input  wire logic             i_push,
   input  wire logic             i_pop,
   input  wire logic [WIDTH-1:0] i_data,
   output logic      [WIDTH-1:0] o_data,
   output logic      [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = i_push && (r_count != CW'(DEPTH));
   assign w_do_pop  = i_pop && (r_count != '0);

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I instruction fetch: PC, credit-limited imem requests, fetch
//            buffer and IF/ID register with stall/flush handling.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  wire logic        i_clk,
   input  wire logic        i_rst,
   input  wire logic        i_stall,
   input  wire logic        i_flush,
   input  wire logic [31:0] i_redirect_pc,
   fetch_stage_if.master    imem,
   output logic      [31:0] o_ID_inst,
   output logic      [31:0] o_ID_pc,
   output logic             o_ID_valid
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]  r_pc_q;
   logic [CW-1:0] r_out_cnt;
   logic [CW-1:0] r_drop_cnt;
   fetch_state_e r_state;
   if_id_t       r_if_id;

   logic [CW-1:0] w_fifo_count;
   logic [CW-1:0] w_pc_count;
   logic [CW-1:0] w_flush_drop;
   logic [63:0]   w_fifo_head;
   logic [31:0]   w_resp_pc;
   logic          w_req, w_grant, w_rvalid, w_live, w_load;
   logic          w_fifo_empty, w_pop, w_bypass, w_push;

   assign w_req    = !i_rst && !i_flush &&
                     ((r_out_cnt + w_fifo_count) < CW'(FIFO_DEPTH));
   assign w_grant  = w_req && imem.i_imem_gnt;
   assign w_rvalid = imem.i_imem_rvalid;

   // A response landing in a flush cycle belongs to the wrong path.
   assign w_live       = w_rvalid && (r_drop_cnt == '0) && !i_flush;
   assign w_load       = !i_stall || !r_if_id.valid;
   assign w_fifo_empty = (w_fifo_count == '0);
   assign w_pop        = !i_flush && w_load && !w_fifo_empty;
   assign w_bypass     = !i_flush && w_load && w_fifo_empty && w_live;
   assign w_push       = w_live && !w_bypass;
   assign w_flush_drop = r_out_cnt - CW'(w_rvalid);

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_pc_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (1'b0),
      .i_push  (w_grant),
      .i_pop   (w_rvalid && (w_pc_count != '0)),
      .i_data  (r_pc_q),
      .o_data  (w_resp_pc),
      .o_count (w_pc_count)
   );

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_inst_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (i_flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  ({w_resp_pc, imem.i_imem_rdata}),
      .o_data  (w_fifo_head),
      .o_count (w_fifo_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc_q        <= RESET_PC;
         r_out_cnt     <= '0;
         r_drop_cnt    <= '0;
         r_state       <= RUN;
         r_if_id.inst  <= NOP_INST;
         r_if_id.pc    <= '0;
         r_if_id.valid <= 1'b0;
      end else begin
         assert (!(w_rvalid && (r_out_cnt == '0)));
         r_out_cnt <= r_out_cnt + CW'(w_grant) - CW'(w_rvalid);
         if (i_flush) begin
            r_pc_q        <= i_redirect_pc & ~32'h3;
            r_drop_cnt    <= w_flush_drop;
            r_state       <= (w_flush_drop != '0) ? DRAIN : RUN;
            r_if_id.inst  <= NOP_INST;
            r_if_id.valid <= 1'b0;
         end else begin
            if (w_grant) r_pc_q <= r_pc_q + 32'd4;
            if ((r_state == DRAIN) && w_rvalid) begin
               r_drop_cnt <= r_drop_cnt - 1'b1;
               if (r_drop_cnt == CW'(1)) r_state <= RUN;
            end
            if (w_load) begin
               if (w_pop) begin
                  r_if_id.pc    <= w_fifo_head[63:32];
                  r_if_id.inst  <= w_fifo_head[31:0];
                  r_if_id.valid <= 1'b1;
               end else if (w_bypass) begin
                  r_if_id.pc    <= w_resp_pc;
                  r_if_id.inst  <= imem.i_imem_rdata;
                  r_if_id.valid <= 1'b1;
               end else begin
                  r_if_id.inst  <= NOP_INST;
                  r_if_id.valid <= 1'b0;
               end
            end
         end
      end
   end

   assign imem.o_imem_req  = w_req;
   assign imem.o_imem_addr = r_pc_q;
   assign o_ID_inst        = r_if_id.inst;
   assign o_ID_pc          = r_if_id.pc;
   assign o_ID_valid       = r_if_id.valid;

endmodule
`default_nettype wire
